// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   conversion request, taken when not busy
//   bin      in   binary value, sampled on the accept edge
//   busy     out  high while shifting
//   done     out  one-cycle pulse when results update
//   bcd      out  registered BCD result, digit 0 least significant
//   blank    out  leading-zero blank mask, bit 0 always 0
//   overflow out  value did not fit in DIGITS decimal digits
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     shift_reg;
    logic [4*DIGITS-1:0]  digits, adj, dig_n;
    logic [CW-1:0]        cnt;
    logic                 ovf_acc, carry, last, accept, z;
    logic [DIGITS-1:0]    blank_d;

    assign busy   = state_q == CONV;
    assign done   = state_q == DONE;
    assign accept = start && state_q != CONV;
    assign last   = cnt == CW'(BIN_W - 1);

    // add-3 fixup on every digit, then shift {digits, shift_reg} left by one
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (digits[4*i +: 4] >= 4'd5) ? digits[4*i +: 4] + 4'd3 : digits[4*i +: 4];
        carry = adj[4*DIGITS-1];
        dig_n = {adj[4*DIGITS-2:0], shift_reg[BIN_W-1]};
    end

    // a digit is blank only if it and every digit above it are zero
    always_comb begin
        blank_d = '0;
        z       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z          = z & (dig_n[4*i +: 4] == 4'd0);
            blank_d[i] = z;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CONV)
            state_d = last ? DONE : CONV;
        else if (start)
            state_d = CONV;
        else if (state_q == DONE)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_reg <= '0;
            digits    <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            bcd       <= '0;
            blank     <= BLANK_RST;
            overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                shift_reg <= bin;
                digits    <= '0;
                cnt       <= '0;
                ovf_acc   <= 1'b0;
            end else if (state_q == CONV) begin
                shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                digits    <= dig_n;
                cnt       <= cnt + CW'(1);
                ovf_acc   <= ovf_acc | carry;
                if (last) begin
                    bcd      <= dig_n;
                    blank    <= blank_d;
                    overflow <= ovf_acc | carry;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of bin2bcd_seq with 5-digit and 4-digit instances
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy5, done5, ovf5, busy4, done4, ovf4;
    logic [19:0] bcd5;
    logic [4:0]  blank5;
    logic [15:0] bcd4;
    logic [3:0]  blank4;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n, b, dn;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy5), .done(done5), .bcd(bcd5), .blank(blank5), .overflow(ovf5)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .blank(blank4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ticks until done is seen (bounded); counts busy cycles on the way
    task automatic wait_done(output int ticks, output int busy_n);
        ticks  = 0;
        busy_n = 0;
        while (!done5 && ticks < 40) begin
            if (busy5) busy_n++;
            tick();
            ticks++;
        end
        if (!done5) ticks = -1;
    endtask

    task automatic run(input logic [15:0] v, output int done_at, output int busy_n);
        int t;
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(t, busy_n);
        done_at = (t < 0) ? -1 : t + 1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy5, 0);
        chk("rst_done", done5, 0);
        chk("rst_bcd", bcd5, 0);
        chk("rst_blank", blank5, 5'b11110);
        chk("rst_ovf", ovf5, 0);
        chk("rst_blank4", blank4, 4'b1110);
        rst = 1'b0;
        tick();

        run(16'hFFFF, n, b);
        chk("t1_done_at", n, 17);
        chk("t1_busy_n", b, 16);
        chk("t1_bcd", bcd5, 20'h65535);
        chk("t1_blank", blank5, 5'b00000);
        chk("t1_ovf", ovf5, 0);
        chk("t1_bcd4", bcd4, 16'h5535);
        chk("t1_ovf4", ovf4, 1);
        tick();
        chk("t1_pulse", done5, 0);
        chk("t1_idle", busy5, 0);

        run(16'd0, n, b);
        chk("t2_bcd", bcd5, 20'h00000);
        chk("t2_blank", blank5, 5'b11110);
        chk("t2_ovf", ovf5, 0);

        run(16'd1234, n, b);
        chk("t3_bcd", bcd5, 20'h01234);
        chk("t3_blank", blank5, 5'b10000);

        run(16'd10000, n, b);
        chk("t4_ovf4", ovf4, 1);
        chk("t4_bcd4", bcd4, 16'h0000);
        chk("t4_blank4", blank4, 4'b1110);
        chk("t4_bcd5", bcd5, 20'h10000);
        chk("t4_ovf5", ovf5, 0);
        run(16'd9999, n, b);
        chk("t4b_ovf4", ovf4, 0);
        chk("t4b_bcd4", bcd4, 16'h9999);

        bin   = 16'd300;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin   = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 16'd0;
        chk("t5_hold", bcd5, 20'h09999);
        wait_done(n, b);
        chk("t5_ign_lat", n, 11);
        chk("t5_ign_bcd", bcd5, 20'h00300);
        bin   = 16'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 16'd999;
        wait_done(n, b);
        chk("t5_b2b_lat", (n < 0) ? -1 : n + 1, 17);
        chk("t5_b2b_busy", b, 16);
        chk("t5_b2b_bcd", bcd5, 20'h00042);
        chk("t5_b2b_blank", blank5, 5'b11100);

        tick();
        bin   = 16'd999;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("t6_mid_bcd", bcd5, 20'h00042);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            if (done5) dn++;
            tick();
        end
        chk("t6_no_done", dn, 0);
        chk("t6_bcd", bcd5, 0);
        chk("t6_blank", blank5, 5'b11110);
        chk("t6_busy", busy5, 0);
        run(16'd500, n, b);
        chk("t6_done_at", n, 17);
        chk("t6_bcd500", bcd5, 20'h00500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
